// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// Carries the operand request (start, a, b, borrow_in) and the result side
// (busy, done, diff, borrow_out, and ovf when SERIAL_SUB_OVF_EN is defined).
//   master : requester, drives start/a/b/borrow_in, observes status and result
//   slave  : the subtractor, consumes the request and drives status and result
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial WIDTH-bit subtractor (a - b - borrow_in), one full-subtractor slice per clock, LSB first.
// Latency : start accepted at edge 0 -> diff/borrow_out valid and done pulses after edge WIDTH; one result per WIDTH+1 cycles.
// Backpr. : no stall path; start is only sampled in IDLE or DONE, starts while busy are dropped and the in-flight op is unaffected.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears FSM, datapath and result)
//   bus        serial_subtractor_if.slave:
//                start/a/b/borrow_in  request, captured on the accepting edge
//                busy                 high while bit slices are being processed
//                done                 one-cycle pulse, result valid
//                diff/borrow_out      result, held until the next completion
//                ovf                  signed overflow, only with SERIAL_SUB_OVF_EN
// Optional feature macro: SERIAL_SUB_OVF_EN (adds ovf output and the operand sign-capture flops).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Operand shift registers: bit 0 is always the slice being processed.
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    // Partial difference; each new bit enters at the MSB so after WIDTH
    // shifts the LSB-first stream lines up as a normal binary word.
    logic [WIDTH-1:0]  work;
    logic              z;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  diff_q;
    logic              borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    logic              a_sign;
    logic              b_sign;
    logic              ovf_q;
`endif

    logic              load;
    logic              shift;
    logic              last;
    logic              d_bit;
    logic              bn_bit;
    logic [WIDTH-1:0]  work_nxt;

    // Full-subtractor slice on the current LSBs with the fed-back borrow.
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ z;
        bn_bit   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & z) | (b_sh[0] & z);
        work_nxt = {d_bit, work[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Accepting here gives back-to-back operations without an IDLE gap.
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working datapath: operand capture, shifting, borrow feedback, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            work <= '0;
            z    <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            work <= '0;
            z    <= bus.borrow_in;
            cnt  <= '0;
        end else if (shift) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            work <= work_nxt;
            z    <= bn_bit;
            cnt  <= cnt + CW'(1);
        end
    end

    // Result registers: only updated on the edge that processes the MSB slice,
    // so they hold across IDLE and while the next operation is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (shift && last) begin
            diff_q   <= work_nxt;
            borrow_q <= bn_bit;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // The operand registers are shifted away by the MSB slice, so the sign
    // bits are kept separately from the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (load) begin
                a_sign <= bus.a[WIDTH-1];
                b_sign <= bus.b[WIDTH-1];
            end
            if (shift && last) begin
                // Operands of opposite sign whose result sign differs from the minuend.
                ovf_q <= (a_sign != b_sign) && (d_bit != a_sign);
            end
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule
